mips_bus_initiator: RTL and testbench

Bus-master front end for the MIPS core. It accepts single-word instruction-fetch and data load/store requests from the core pipeline. It arbitrates between them and drives the memory bus (address/read/write/byteenable/writedata, with waitrequest stall and registered readdata). The block sits between the core datapath and the external memory responder inside mips_cpu_bus, and owns all bus handshaking so the core sees a simple req/ready interface.

---
 rtl/mips_bus_initiator_if.sv | 21 ++
 rtl/mips_bus_initiator.sv | 163 ++++++++++++++++
 tb/tb_mips_bus_initiator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_initiator_if.sv
// Memory-bus bundle between the MIPS bus initiator (master) and the external
// memory responder (slave): word address, strobes, byte enables and stall.
interface mips_bus_initiator_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_initiator.sv
// Single-outstanding bus master for the MIPS core: arbitrates fetch and data
// requests (data first), runs the bus handshake and aborts stalled accesses.
module mips_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        bus_error,
  output logic        busy,
  mips_bus_initiator_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, BUS, RDWAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] address_reg, address_next;
  logic [31:0] writedata_reg, writedata_next;
  logic [3:0]  byteenable_reg, byteenable_next;
  logic        read_reg, read_next;
  logic        write_reg, write_next;
  logic        src_data_reg, src_data_next;
  logic [CW-1:0] stall_reg, stall_next;
  logic [31:0] fetch_data_reg, fetch_data_next;
  logic [31:0] data_rdata_reg, data_rdata_next;
  logic        error_reg, error_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      address_reg    <= '0;
      writedata_reg  <= '0;
      byteenable_reg <= '0;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
      src_data_reg   <= 1'b0;
      stall_reg      <= '0;
      fetch_data_reg <= '0;
      data_rdata_reg <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      address_reg    <= address_next;
      writedata_reg  <= writedata_next;
      byteenable_reg <= byteenable_next;
      read_reg       <= read_next;
      write_reg      <= write_next;
      src_data_reg   <= src_data_next;
      stall_reg      <= stall_next;
      fetch_data_reg <= fetch_data_next;
      data_rdata_reg <= data_rdata_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    address_next    = address_reg;
    writedata_next  = writedata_reg;
    byteenable_next = byteenable_reg;
    read_next       = read_reg;
    write_next      = write_reg;
    src_data_next   = src_data_reg;
    stall_next      = stall_reg;
    fetch_data_next = fetch_data_reg;
    data_rdata_next = data_rdata_reg;
    error_next      = error_reg;

    case (state_reg)
      IDLE: begin
        // Data wins a tie so loads/stores never starve behind fetches
        if (data_req) begin
          state_next      = BUS;
          src_data_next   = 1'b1;
          stall_next      = '0;
          address_next    = {data_addr[31:2], 2'b00};
          if (data_we) begin
            write_next      = 1'b1;
            byteenable_next = data_be;
            writedata_next  = data_wdata;
          end else begin
            read_next       = 1'b1;
            byteenable_next = 4'b1111;
            writedata_next  = '0;
          end
        end else if (fetch_req) begin
          state_next      = BUS;
          src_data_next   = 1'b0;
          stall_next      = '0;
          address_next    = {fetch_addr[31:2], 2'b00};
          read_next       = 1'b1;
          byteenable_next = 4'b1111;
          writedata_next  = '0;
        end
      end

      BUS: begin
        if (!bus.waitrequest) begin
          state_next      = write_reg ? DONE : RDWAIT;
          read_next       = 1'b0;
          write_next      = 1'b0;
          address_next    = '0;
          byteenable_next = '0;
          writedata_next  = '0;
        end else if (stall_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          // Abort skips RDWAIT so the read-data registers keep their value
          state_next      = DONE;
          read_next       = 1'b0;
          write_next      = 1'b0;
          address_next    = '0;
          byteenable_next = '0;
          writedata_next  = '0;
          error_next      = 1'b1;
        end else begin
          stall_next = stall_reg + 1'b1;
        end
      end

      RDWAIT: begin
        state_next = DONE;
        if (src_data_reg) begin
          data_rdata_next = bus.readdata;
        end else begin
          fetch_data_next = bus.readdata;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fetch_ready    = (state_reg == DONE) && !src_data_reg;
  assign data_ready     = (state_reg == DONE) &&  src_data_reg;
  assign busy           = (state_reg != IDLE);
  assign fetch_data     = fetch_data_reg;
  assign data_rdata     = data_rdata_reg;
  assign bus_error      = error_reg;

  assign bus.address    = address_reg;
  assign bus.read       = read_reg;
  assign bus.write      = write_reg;
  assign bus.writedata  = writedata_reg;
  assign bus.byteenable = byteenable_reg;

endmodule

// File: tb/tb_mips_bus_initiator.sv
// Directed bench for mips_bus_initiator: fetch, priority, store, stalled load,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_mips_bus_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_be = '0;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        bus_error;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  logic [31:0] model_fd = '0;
  logic [31:0] model_dr = '0;
  logic        model_err = 1'b0;

  mips_bus_initiator_if mbus ();

  mips_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_be     (data_be),
    .data_ready  (data_ready),
    .data_rdata  (data_rdata),
    .bus_error   (bus_error),
    .busy        (busy),
    .bus         (mbus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mbus.read && mbus.write) overlap++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string tag, input bit is_data, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] rdval, input int nwait);
    int strobe_cycles, ready_cycle, other_ready, exp_strobe, exp_ready;
    bit timed_out, stable;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    timed_out  = (nwait >= TO);
    exp_strobe = timed_out ? TO : nwait + 1;
    exp_ready  = exp_strobe + ((we || timed_out) ? 1 : 2);
    exp_addr   = {addr[31:2], 2'b00};
    exp_be     = we ? be : 4'b1111;
    @(negedge clk);
    mbus.readdata    = rdval;
    mbus.waitrequest = 1'b0;
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata; data_be = be;
    end else begin
      fetch_req = 1'b1; fetch_addr = addr;
    end
    @(posedge clk);
    strobe_cycles = 0; ready_cycle = 0; other_ready = 0; stable = 1'b1;
    for (int k = 1; k <= 60 && ready_cycle == 0; k++) begin
      @(negedge clk);
      if (mbus.read || mbus.write) begin
        strobe_cycles++;
        if (mbus.address !== exp_addr || mbus.byteenable !== exp_be ||
            mbus.read !== !we || mbus.write !== we || (we && mbus.writedata !== wdata))
          stable = 1'b0;
      end
      if (is_data ? data_ready : fetch_ready) begin
        ready_cycle = k;
        data_req = 1'b0;
        fetch_req = 1'b0;
      end
      if (is_data ? fetch_ready : data_ready) other_ready++;
      mbus.waitrequest = (k <= nwait) && (ready_cycle == 0);
    end
    mbus.waitrequest = 1'b0;
    if (timed_out) model_err = 1'b1;
    else if (!we) begin
      if (is_data) model_dr = rdval; else model_fd = rdval;
    end
    check({tag, "_strobe_cycles"}, 32'(strobe_cycles), 32'(exp_strobe));
    check({tag, "_strobe_stable"}, 32'(stable), 32'd1);
    check({tag, "_ready_cycle"}, 32'(ready_cycle), 32'(exp_ready));
    check({tag, "_other_ready"}, 32'(other_ready), 32'd0);
    check({tag, "_fetch_data"}, fetch_data, model_fd);
    check({tag, "_data_rdata"}, data_rdata, model_dr);
    check({tag, "_bus_error"}, 32'(bus_error), 32'(model_err));
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy, (fetch_ready | data_ready)}, 32'd0);
    $display("txn %s addr=%h strobe_cycles=%0d ready_cycle=%0d", tag, addr, strobe_cycles, ready_cycle);
  endtask

  initial begin
    int dcyc, fcyc, ready_seen;
    logic [31:0] first_addr, fetch_issue_addr;
    mbus.waitrequest = 1'b0;
    mbus.readdata    = '0;

    #12;
    check("reset_outputs",
          {mbus.address | mbus.writedata | fetch_data | data_rdata},
          32'd0);
    check("reset_ctrl",
          {22'd0, mbus.read, mbus.write, mbus.byteenable, busy, bus_error, fetch_ready, data_ready},
          32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("fetch_boot", 1'b0, 1'b0, 32'hBFC00000, 32'h0, 4'h0, 32'h3C08BFC0, 0);

    // Simultaneous fetch and load: load must go first
    @(negedge clk);
    mbus.readdata = 32'h0000000F;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'hBFC0002C;
    fetch_req = 1'b1; fetch_addr = 32'hBFC00004;
    @(posedge clk);
    dcyc = 0; fcyc = 0; first_addr = '0; fetch_issue_addr = '0;
    for (int k = 1; k <= 40 && fcyc == 0; k++) begin
      @(negedge clk);
      if (k == 1) first_addr = mbus.address;
      if (k == 5) fetch_issue_addr = mbus.address;
      if (data_ready) begin dcyc = k; data_req = 1'b0; mbus.readdata = 32'h27BDFFE8; end
      if (fetch_ready) begin fcyc = k; fetch_req = 1'b0; end
    end
    model_dr = 32'h0000000F; model_fd = 32'h27BDFFE8;
    check("prio_first_addr", first_addr, 32'hBFC0002C);
    check("prio_data_cycle", 32'(dcyc), 32'd3);
    check("prio_fetch_addr", fetch_issue_addr, 32'hBFC00004);
    check("prio_fetch_cycle", 32'(fcyc), 32'd7);
    check("prio_data_rdata", data_rdata, model_dr);
    check("prio_fetch_data", fetch_data, model_fd);
    $display("txn priority data_cycle=%0d fetch_cycle=%0d", dcyc, fcyc);

    run_txn("store_byte", 1'b1, 1'b1, 32'hBFC00031, 32'h000000AB, 4'b0010, 32'h0, 0);
    run_txn("load_wait3", 1'b1, 1'b0, 32'hBFC00040, 32'h0, 4'h0, 32'h12345678, 3);
    run_txn("load_wait7", 1'b1, 1'b0, 32'hBFC00046, 32'h0, 4'h0, 32'hCAFEF00D, TO - 1);
    run_txn("load_timeout", 1'b1, 1'b0, 32'hBFC00050, 32'h0, 4'h0, 32'hDEADBEEF, 100);
    run_txn("fetch_sticky", 1'b0, 1'b0, 32'hBFC00008, 32'h0, 4'h0, 32'h8C020000, 0);

    // Asynchronous reset while the load is stalled in BUS
    @(negedge clk);
    mbus.waitrequest = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'hBFC00060;
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_read", 32'(mbus.read), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_bus", {mbus.address | mbus.writedata}, 32'd0);
    check("rst_async_ctrl",
          {26'd0, mbus.read, mbus.write, busy, bus_error, fetch_ready, data_ready}, 32'd0);
    check("rst_async_data", {fetch_data | data_rdata}, 32'd0);
    data_req = 1'b0;
    mbus.waitrequest = 1'b0;
    ready_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (fetch_ready || data_ready) ready_seen++;
    end
    check("rst_no_ready", 32'(ready_seen), 32'd0);
    reset = 1'b1;
    model_fd = '0; model_dr = '0; model_err = 1'b0;
    $display("txn reset_in_bus ready_pulses=%0d", ready_seen);

    run_txn("fetch_after_rst", 1'b0, 1'b0, 32'hBFC00010, 32'h0, 4'h0, 32'h24080001, 0);

    check("one_strobe_only", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
